// File: rtl/adam_stream_downsizer.sv
// Splits each wide slave word into RATIO narrow master beats, one per cycle.
// The last beat's handshake can accept the next word, so back-to-back words leave no bubble.
module adam_stream_downsizer #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned RATIO     = 4,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [WIDTH*RATIO-1:0] slv_data_i,
    input  logic                   slv_valid_i,
    output logic                   slv_ready_o,
    output logic [WIDTH-1:0]       mst_data_o,
    output logic                   mst_valid_o,
    input  logic                   mst_ready_i
);
    localparam int unsigned     CW   = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CW-1:0]   LAST = CW'(RATIO - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [WIDTH*RATIO-1:0] data_q, data_d;
    logic [CW-1:0]          sel;
    logic                   last;

    assign last       = (cnt_q == LAST);
    assign sel        = MSB_FIRST ? (LAST - cnt_q) : cnt_q;
    assign mst_data_o = data_q[sel*WIDTH +: WIDTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        slv_ready_o = 1'b0;
        mst_valid_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                slv_ready_o = 1'b1;
                if (slv_valid_i) begin
                    data_d  = slv_data_i;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                mst_valid_o = 1'b1;
                // Ready flows through from downstream on the last beat only.
                slv_ready_o = last && mst_ready_i;
                if (mst_ready_i) begin
                    if (!last) begin
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        cnt_d = '0;
                        if (slv_valid_i) begin
                            data_d = slv_data_i;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst_i) begin
            slv_ready_o = 1'b0;
            mst_valid_o = 1'b0;
        end
    end
endmodule

// File: tb/tb_adam_stream_downsizer.sv
// Directed bench: LSB/MSB-first split, back-to-back, stall, mid-word reset,
// and a RATIO=1 pass-through with random downstream ready.
module tb_adam_stream_downsizer;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_data;
    logic        s_valid;
    logic        m_ready;
    logic        a_s_ready, a_m_valid, b_s_ready, b_m_valid;
    logic [7:0]  a_m_data, b_m_data;
    logic [31:0] c_s_data, c_m_data;
    logic        c_s_valid, c_s_ready, c_m_valid, c_m_ready;

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    adam_stream_downsizer #(.WIDTH(8), .RATIO(4), .MSB_FIRST(1'b0)) u_a (
        .clk_i(clk), .rst_i(rst),
        .slv_data_i(s_data), .slv_valid_i(s_valid), .slv_ready_o(a_s_ready),
        .mst_data_o(a_m_data), .mst_valid_o(a_m_valid), .mst_ready_i(m_ready)
    );

    adam_stream_downsizer #(.WIDTH(8), .RATIO(4), .MSB_FIRST(1'b1)) u_b (
        .clk_i(clk), .rst_i(rst),
        .slv_data_i(s_data), .slv_valid_i(s_valid), .slv_ready_o(b_s_ready),
        .mst_data_o(b_m_data), .mst_valid_o(b_m_valid), .mst_ready_i(m_ready)
    );

    adam_stream_downsizer #(.WIDTH(32), .RATIO(1), .MSB_FIRST(1'b0)) u_c (
        .clk_i(clk), .rst_i(rst),
        .slv_data_i(c_s_data), .slv_valid_i(c_s_valid), .slv_ready_o(c_s_ready),
        .mst_data_o(c_m_data), .mst_valid_o(c_m_valid), .mst_ready_i(c_m_ready)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic beat(input string tag, input logic [7:0] a_exp,
                        input logic [7:0] b_exp, input logic rdy_exp);
        check({tag, "_valid"}, {31'd0, a_m_valid}, 32'd1);
        check({tag, "_data"}, {24'd0, a_m_data}, {24'd0, a_exp});
        check({tag, "_msb"}, {24'd0, b_m_data}, {24'd0, b_exp});
        check({tag, "_srdy"}, {31'd0, a_s_ready}, {31'd0, rdy_exp});
    endtask

    initial begin
        int sent;
        int got;
        logic hs_in;
        logic hs_out;
        rst       = 1'b1;
        s_data    = '0;
        s_valid   = 1'b0;
        m_ready   = 1'b0;
        c_s_data  = '0;
        c_s_valid = 1'b0;
        c_m_ready = 1'b0;

        tick; settle;
        check("rst_srdy", {31'd0, a_s_ready}, 32'd0);
        check("rst_mvalid", {31'd0, a_m_valid}, 32'd0);
        check("rst_c_srdy", {31'd0, c_s_ready}, 32'd0);
        repeat (4) tick;
        rst = 1'b0;
        settle;
        check("idle_srdy", {31'd0, a_s_ready}, 32'd1);
        check("idle_mvalid", {31'd0, a_m_valid}, 32'd0);

        // LSB first, with MSB-first instance watching the same stream
        s_valid = 1'b1; s_data = 32'hDDCCBBAA; m_ready = 1'b1;
        tick; s_valid = 1'b0; settle;
        beat("lsb0", 8'hAA, 8'hDD, 1'b0);
        tick; settle; beat("lsb1", 8'hBB, 8'hCC, 1'b0);
        tick; settle; beat("lsb2", 8'hCC, 8'hBB, 1'b0);
        tick; settle; beat("lsb3", 8'hDD, 8'hAA, 1'b1);
        tick; settle;
        check("lsb_done", {31'd0, a_m_valid}, 32'd0);
        check("msb_done", {31'd0, b_m_valid}, 32'd0);

        // Back-to-back; next word waits on slv while beats drain
        s_valid = 1'b1; s_data = 32'h44332211;
        tick; s_data = 32'h88776655; settle;
        beat("b2b0", 8'h11, 8'h44, 1'b0);
        tick; settle; beat("b2b1", 8'h22, 8'h33, 1'b0);
        tick; settle; beat("b2b2", 8'h33, 8'h22, 1'b0);
        tick; settle; beat("b2b3", 8'h44, 8'h11, 1'b1);
        tick; s_valid = 1'b0; settle;
        beat("b2b4", 8'h55, 8'h88, 1'b0);
        tick; settle; beat("b2b5", 8'h66, 8'h77, 1'b0);
        tick; settle; beat("b2b6", 8'h77, 8'h66, 1'b0);
        tick; settle; beat("b2b7", 8'h88, 8'h55, 1'b1);
        tick; settle;
        check("b2b_done", {31'd0, a_m_valid}, 32'd0);

        // Backpressure on beat 2; a stray slv word must be ignored
        s_valid = 1'b1; s_data = 32'hDDCCBBAA;
        tick; s_valid = 1'b0; settle;
        beat("bp0", 8'hAA, 8'hDD, 1'b0);
        tick; settle; beat("bp1", 8'hBB, 8'hCC, 1'b0);
        tick; m_ready = 1'b0; s_valid = 1'b1; s_data = 32'h12345678; settle;
        beat("bp_st0", 8'hCC, 8'hBB, 1'b0);
        tick; settle; beat("bp_st1", 8'hCC, 8'hBB, 1'b0);
        tick; settle; beat("bp_st2", 8'hCC, 8'hBB, 1'b0);
        tick; m_ready = 1'b1; s_valid = 1'b0; settle;
        beat("bp_go", 8'hCC, 8'hBB, 1'b0);
        tick; settle; beat("bp3", 8'hDD, 8'hAA, 1'b1);
        tick; settle;
        check("bp_done", {31'd0, a_m_valid}, 32'd0);

        // Reset after beat 1 transfers; the rest of the word is discarded
        s_valid = 1'b1; s_data = 32'hDDCCBBAA;
        tick; s_valid = 1'b0; settle;
        beat("rm0", 8'hAA, 8'hDD, 1'b0);
        tick; settle; beat("rm1", 8'hBB, 8'hCC, 1'b0);
        tick; rst = 1'b1; settle;
        check("rm_rst_mvalid", {31'd0, a_m_valid}, 32'd0);
        check("rm_rst_srdy", {31'd0, a_s_ready}, 32'd0);
        tick; rst = 1'b0; settle;
        check("rm_post_mvalid", {31'd0, a_m_valid}, 32'd0);
        check("rm_post_srdy", {31'd0, a_s_ready}, 32'd1);
        s_valid = 1'b1; s_data = 32'h04030201;
        tick; s_valid = 1'b0; settle;
        beat("rm_n0", 8'h01, 8'h04, 1'b0);
        tick; settle; beat("rm_n1", 8'h02, 8'h03, 1'b0);
        tick; settle; beat("rm_n2", 8'h03, 8'h02, 1'b0);
        tick; settle; beat("rm_n3", 8'h04, 8'h01, 1'b1);
        tick; settle;
        check("rm_done", {31'd0, a_m_valid}, 32'd0);

        // RATIO=1 pass-through with random downstream ready
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 60 && got < 3; cyc++) begin
            c_m_ready = (cyc >= 30) ? 1'b1 : 1'($urandom_range(0, 1));
            c_s_valid = (sent < 3);
            c_s_data  = sent + 1;
            settle;
            check("c_srdy", {31'd0, c_s_ready},
                  {31'd0, (!c_m_valid || c_m_ready)});
            hs_in  = c_s_valid && c_s_ready;
            hs_out = c_m_valid && c_m_ready;
            if (hs_out) begin
                check("c_data", c_m_data, got + 1);
                got++;
            end
            if (hs_in) sent++;
            tick;
        end
        c_s_valid = 1'b0;
        check("c_count", got, 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
